// File: rtl/eoc_mon_pkg.sv
// Shared types and constants for the end-of-computation monitor.
package eoc_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } eoc_state_e;

  localparam logic signed [1:0] EXIT_SUCCESS = 2'sb00;
  localparam logic signed [1:0] EXIT_FAIL    = 2'sb01;
  localparam logic signed [1:0] EXIT_ERROR   = 2'sb11;

  function automatic logic ch_valid(input logic [4:0] ch, input int num_ch);
    return int'(ch) < num_ch;
  endfunction

endpackage

// File: rtl/eoc_channel.sv
// One monitored channel: sticky eoc latch, first-write status latch and
// fail/duplicate flags. All outputs are registered.
module eoc_channel #(
  parameter int STATUS_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  input  logic                eoc,
  input  logic                wr,
  input  logic [STATUS_W-1:0] status,
  output logic                ch_done,
  output logic                ch_fail,
  output logic                dup_err
);

  logic                eoc_seen, stat_seen;
  logic [STATUS_W-1:0] code;
  logic                eoc_n, stat_n, dup_n;
  logic [STATUS_W-1:0] code_n;

  always_comb begin
    eoc_n  = eoc_seen;
    stat_n = stat_seen;
    dup_n  = dup_err;
    code_n = code;
    if (clear) begin
      eoc_n  = 1'b0;
      stat_n = 1'b0;
      dup_n  = 1'b0;
      code_n = '0;
    end else if (run) begin
      if (eoc) eoc_n = 1'b1;
      // only the first write keeps its code; later ones just flag the error
      if (wr) begin
        if (stat_seen) begin
          dup_n = 1'b1;
        end else begin
          stat_n = 1'b1;
          code_n = status;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_seen  <= 1'b0;
      stat_seen <= 1'b0;
      code      <= '0;
      dup_err   <= 1'b0;
      ch_done   <= 1'b0;
      ch_fail   <= 1'b0;
    end else begin
      eoc_seen  <= eoc_n;
      stat_seen <= stat_n;
      code      <= code_n;
      dup_err   <= dup_n;
      ch_done   <= eoc_n & stat_n;
      ch_fail   <= dup_n | (stat_n & (code_n != '0));
    end
  end

endmodule

// File: rtl/eoc_status_monitor.sv
// End-of-computation monitor: per-channel done/return-code tracking, cycle
// timeout and a registered aggregate exit code.
//
// state   | meaning
// IDLE    | not armed since reset
// RUN     | armed; counting cycles and latching channel events
// DONE    | every channel completed; exit code valid
// TIMEOUT | cycle limit reached first; exit code is error
module eoc_status_monitor
  import eoc_mon_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int STATUS_W = 32,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_CH-1:0]    eoc_i,
  input  logic                 status_valid_i,
  input  logic [4:0]           status_ch_i,
  input  logic [STATUS_W-1:0]  status_i,
  input  logic [CNT_W-1:0]     timeout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic signed [1:0]    exit_code_o,
  output logic [NUM_CH-1:0]    ch_done_o,
  output logic [NUM_CH-1:0]    ch_fail_o,
  output logic [CNT_W-1:0]     cycles_o
);

  eoc_state_e        state, state_n;
  logic [CNT_W-1:0]  timeout_q, cycles_n;
  logic [NUM_CH-1:0] dup_vec;
  logic              in_run, all_done, timeout_hit, dup_any, wr_ok;

  assign in_run   = (state == ST_RUN);
  assign cycles_n = (&cycles_o) ? cycles_o : cycles_o + CNT_W'(1);
  assign all_done = &ch_done_o;
  assign dup_any  = |dup_vec;
  assign wr_ok    = status_valid_i && ch_valid(status_ch_i, NUM_CH);

  // compare against the value the counter takes on this edge, so the limit
  // and the TIMEOUT state become visible together
  assign timeout_hit = (timeout_q != '0) && (cycles_n == timeout_q);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    eoc_channel #(.STATUS_W(STATUS_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (start_i),
      .run     (in_run),
      .eoc     (eoc_i[c]),
      .wr      (wr_ok && (status_ch_i == 5'(c))),
      .status  (status_i),
      .ch_done (ch_done_o[c]),
      .ch_fail (ch_fail_o[c]),
      .dup_err (dup_vec[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_i) begin
      state_n = ST_RUN;
    end else if (state == ST_RUN) begin
      if (all_done)         state_n = ST_DONE;
      else if (timeout_hit) state_n = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      exit_code_o <= EXIT_ERROR;
      cycles_o    <= '0;
      timeout_q   <= '0;
    end else begin
      busy_o <= (state_n == ST_RUN);
      done_o <= (state_n == ST_DONE) || (state_n == ST_TIMEOUT);
      if (start_i) begin
        cycles_o    <= '0;
        timeout_q   <= timeout_i;
        exit_code_o <= EXIT_ERROR;
      end else if (in_run) begin
        cycles_o <= cycles_n;
        if (state_n == ST_DONE)
          exit_code_o <= dup_any ? EXIT_ERROR : ((|ch_fail_o) ? EXIT_FAIL : EXIT_SUCCESS);
        else if (state_n == ST_TIMEOUT)
          exit_code_o <= EXIT_ERROR;
      end
    end
  end

endmodule
